// File: rtl/cacheline_adapter.sv
// Cacheline adapter: converts 256-bit L2 line fills and write-backs
// into four 64-bit DRAM bursts.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address_i,
  input  logic [255:0] line_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic [31:0]  address_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [1:0]     cnt;
  logic [31:0]    addr_q;
  logic [255:0]   line_q;
  logic           beat;

  assign beat = resp_i & ((state == RD) | (state == WR));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (write_i)     state_n = WR;
        else if (read_i) state_n = RD;
      end
      RD, WR: begin
        if (beat && cnt == 2'd3) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counter is held at zero while idle, so each burst starts at beat 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 2'd0;
      addr_q <= '0;
      line_q <= '0;
      line_o <= '0;
    end else if (state == IDLE) begin
      cnt <= 2'd0;
      if (write_i) begin
        addr_q <= address_i;
        line_q <= line_i;
      end else if (read_i) begin
        addr_q <= address_i;
      end
    end else if (beat) begin
      cnt <= cnt + 2'd1;
      if (state == RD) line_o[{cnt, 6'd0} +: 64] <= burst_i;
    end
  end

  assign address_o = {addr_q[31:5], 5'b0};
  assign read_o    = (state == RD);
  assign write_o   = (state == WR);
  assign resp_o    = (state == DONE);
  assign burst_o   = (state == WR) ? line_q[{cnt, 6'd0} +: 64] : 64'd0;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed table-driven bench for cacheline_adapter.
// Each row: inputs for one cycle and the outputs expected in that cycle.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  always #5 clk = ~clk;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .line_i    (line_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  typedef struct {
    logic         rst;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
    logic         resp;
    logic [63:0]  burst;
    logic         e_rd;
    logic         e_wr;
    logic         e_resp;
    logic [31:0]  e_addr;
    logic [63:0]  e_burst;
    logic         cl;
    logic [255:0] e_line;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [255:0] LW    = {64'hD, 64'hC, 64'hB, 64'hA};
  localparam logic [255:0] FILL1 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
  localparam logic [255:0] PART2 = {64'hA3, 64'hA2, 64'hA1, 64'hB0};
  localparam logic [255:0] FILL2 = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
  localparam logic [255:0] FILL3 = {64'hE3, 64'hE2, 64'hE1, 64'hE0};

  task automatic add(
    input logic rs, input logic rd, input logic wr,
    input logic [31:0] a, input logic [255:0] l,
    input logic rp, input logic [63:0] b,
    input logic erd, input logic ewr, input logic erp,
    input logic [31:0] ea, input logic [63:0] eb,
    input logic cl, input logic [255:0] el);
    vec_t v;
    v.rst = rs; v.rd = rd; v.wr = wr; v.addr = a;
    v.line = l; v.resp = rp; v.burst = b;
    v.e_rd = erd; v.e_wr = ewr; v.e_resp = erp;
    v.e_addr = ea; v.e_burst = eb;
    v.cl = cl; v.e_line = el;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s got %h want %h", row, nm, act, exp);
    end
  endtask

  initial begin
    // read fill, address aligned down to 32 bytes
    add(0,1,0,32'h12345678,0,0,0,   0,0,0,32'h0,0,1,0);
    add(0,0,0,0,0,1,64'hA0,          1,0,0,32'h12345660,0,0,0);
    add(0,0,0,0,0,1,64'hA1,          1,0,0,32'h12345660,0,0,0);
    add(0,0,0,0,0,1,64'hA2,          1,0,0,32'h12345660,0,0,0);
    add(0,0,0,0,0,1,64'hA3,          1,0,0,32'h12345660,0,0,0);
    // DONE: strobe ignored here
    add(0,0,0,0,0,1,64'hFF,          0,0,1,32'h12345660,0,1,FILL1);
    // simultaneous read+write: write wins
    add(0,1,1,32'hCAFEBABF,LW,0,0,   0,0,0,32'h12345660,0,1,FILL1);
    // inputs change mid-write: ignored
    add(0,1,0,32'h0,'1,1,0,          0,1,0,32'hCAFEBAA0,64'hA,0,0);
    add(0,0,0,0,0,1,0,               0,1,0,32'hCAFEBAA0,64'hB,0,0);
    add(0,0,0,0,0,1,0,               0,1,0,32'hCAFEBAA0,64'hC,0,0);
    add(0,0,0,0,0,1,0,               0,1,0,32'hCAFEBAA0,64'hD,0,0);
    // read held through DONE, accepted only in IDLE
    add(0,1,0,32'h40,0,0,0,          0,0,1,32'hCAFEBAA0,0,1,FILL1);
    add(0,1,0,32'h40,0,0,0,          0,0,0,32'hCAFEBAA0,0,1,FILL1);
    // stalled beats 1,0,0,1,0,1,1
    add(0,0,0,0,0,1,64'hB0,          1,0,0,32'h40,0,0,0);
    add(0,0,0,0,0,0,64'hEE,          1,0,0,32'h40,0,0,0);
    add(0,0,0,0,0,0,64'hEE,          1,0,0,32'h40,0,1,PART2);
    add(0,0,0,0,0,1,64'hB1,          1,0,0,32'h40,0,1,PART2);
    add(0,0,0,0,0,0,64'hEE,          1,0,0,32'h40,0,0,0);
    add(0,0,0,0,0,1,64'hB2,          1,0,0,32'h40,0,0,0);
    add(0,0,0,0,0,1,64'hB3,          1,0,0,32'h40,0,0,0);
    add(0,0,0,0,0,0,0,               0,0,1,32'h40,0,1,FILL2);
    // read interrupted by reset after 2 beats
    add(0,1,0,32'h80,0,0,0,          0,0,0,32'h40,0,1,FILL2);
    add(0,0,0,0,0,1,64'hC0,          1,0,0,32'h80,0,0,0);
    add(0,0,0,0,0,1,64'hC1,          1,0,0,32'h80,0,0,0);
    add(1,0,0,0,0,0,0,               1,0,0,32'h80,0,0,0);
    // request right after reset
    add(0,1,0,32'h100,0,0,0,         0,0,0,32'h0,0,1,0);
    add(0,0,0,0,0,1,64'hE0,          1,0,0,32'h100,0,0,0);
    add(0,0,0,0,0,1,64'hE1,          1,0,0,32'h100,0,0,0);
    add(0,0,0,0,0,1,64'hE2,          1,0,0,32'h100,0,0,0);
    add(0,0,0,0,0,1,64'hE3,          1,0,0,32'h100,0,0,0);
    add(0,0,0,0,0,0,0,               0,0,1,32'h100,0,1,FILL3);
    add(0,0,0,0,0,0,0,               0,0,0,32'h100,0,1,FILL3);

    rst = 1'b1;
    read_i = 1'b0;
    write_i = 1'b0;
    address_i = '0;
    line_i = '0;
    burst_i = '0;
    resp_i = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst       = vq[i].rst;
      read_i    = vq[i].rd;
      write_i   = vq[i].wr;
      address_i = vq[i].addr;
      line_i    = vq[i].line;
      resp_i    = vq[i].resp;
      burst_i   = vq[i].burst;
      #1;
      chk("read_o",    i, 256'(read_o),    256'(vq[i].e_rd));
      chk("write_o",   i, 256'(write_o),   256'(vq[i].e_wr));
      chk("resp_o",    i, 256'(resp_o),    256'(vq[i].e_resp));
      chk("address_o", i, 256'(address_o), 256'(vq[i].e_addr));
      chk("burst_o",   i, 256'(burst_o),   256'(vq[i].e_burst));
      chk("rd_wr_excl", i, 256'(read_o & write_o), 256'(0));
      if (vq[i].cl)
        chk("line_o", i, line_o, vq[i].e_line);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
